decryption_switch_ctrl: RTL and testbench

Sequencing controller that makes cipher reconfiguration safe on the decryption path. It accepts algorithm-select and key change requests from the register side and stalls the upstream input. It waits until the demux/engine/mux datapath has drained, then commits the new select and key atomically. It sits between the decryption register file and the demux, mux and cipher engines, all on the system clock.

---
 rtl/decryption_pkg.sv | 23 ++
 rtl/decryption_switch_ctrl_drain_monitor.sv | 67 ++++++
 rtl/decryption_switch_ctrl.sv | 160 ++++++++++++++++
 tb/tb_decryption_switch_ctrl.sv | 256 +++++++++++++++++++++++++
 4 files changed

// File: rtl/decryption_pkg.sv
// decryption_pkg: shared types and constants for the decryption switch
// sequencing logic (controller state encoding and engine select codes).
package decryption_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    COMMIT = 2'd2
  } state_t;

  typedef logic [1:0] sel_t;

  localparam sel_t SEL_CAESAR  = 2'd0;
  localparam sel_t SEL_SCYTALE = 2'd1;
  localparam sel_t SEL_ZIGZAG  = 2'd2;
  localparam sel_t SEL_INVALID = 2'd3;

  // Engine select codes the datapath can actually route to.
  function automatic logic sel_is_valid(input sel_t sel);
    return sel != SEL_INVALID;
  endfunction

endpackage

// File: rtl/decryption_switch_ctrl_drain_monitor.sv
// drain_monitor: watches the decryption datapath activity while a
// reconfiguration is pending. Counts consecutive quiet cycles and, when
// DECRYPTION_SWITCH_TIMEOUT_EN is defined, the total number of drain cycles.
// Without the macro, timed_out is tied low and no timeout counter exists.
module drain_monitor #(
  parameter int QUIET_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic clk_sys,
  input  logic rst,
  input  logic valid_in,
  input  logic valid_out,
  input  logic engine_busy,
  input  logic clear,
  output logic drained,
  output logic timed_out
);

  localparam logic [CNT_WIDTH-1:0] QUIET_LAST = CNT_WIDTH'(QUIET_CYCLES - 1);

  // Reject parameter sets that would make the drain window meaningless.
  if ((QUIET_CYCLES < 1) || (DRAIN_TIMEOUT <= QUIET_CYCLES)) begin : g_bad_params
    $error("drain_monitor: need QUIET_CYCLES >= 1 and DRAIN_TIMEOUT > QUIET_CYCLES");
  end

  logic                 quiet;
  logic [CNT_WIDTH-1:0] qcnt;

  assign quiet = !valid_in && !valid_out && !engine_busy;

  // Consecutive-quiet counter; any activity restarts the window.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      qcnt <= '0;
    end else if (clear || !quiet) begin
      qcnt <= '0;
    end else if (qcnt != QUIET_LAST) begin
      qcnt <= qcnt + 1'b1;
    end
  end

  // Drained on the cycle that completes the required quiet run.
  assign drained = quiet && (qcnt == QUIET_LAST);

`ifdef DECRYPTION_SWITCH_TIMEOUT_EN
  localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(DRAIN_TIMEOUT - 1);

  logic [CNT_WIDTH-1:0] tcnt;

  // Total drain-cycle counter, independent of activity.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      tcnt <= '0;
    end else if (clear) begin
      tcnt <= '0;
    end else if (tcnt != TIMEOUT_LAST) begin
      tcnt <= tcnt + 1'b1;
    end
  end

  assign timed_out = (tcnt == TIMEOUT_LAST);
`else
  assign timed_out = 1'b0;
`endif

endmodule

// File: rtl/decryption_switch_ctrl.sv
// decryption_switch_ctrl: serialises cipher reconfiguration on the
// decryption path. A change request stalls the input side, waits for the
// demux/engine/mux datapath to drain, then commits select and key together.
// Optional: DECRYPTION_SWITCH_TIMEOUT_EN adds a drain timeout with abort.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no change pending, input side free, waiting for req_i
// DRAIN  | change pending, input held, waiting for a quiet datapath
// COMMIT | done_o high; pending select/key written at this state's exit
module decryption_switch_ctrl
  import decryption_pkg::*;
#(
  parameter int REG_WIDTH     = 16,
  parameter int QUIET_CYCLES  = 4,
  parameter int DRAIN_TIMEOUT = 64,
  parameter int CNT_WIDTH     = 8
) (
  input  logic                 clk_sys,
  input  logic                 rst,
  input  logic                 req_i,
  input  logic [1:0]           req_select_i,
  input  logic [REG_WIDTH-1:0] req_key_i,
  input  logic                 valid_in_i,
  input  logic                 valid_out_i,
  input  logic                 engine_busy_i,
  output logic                 hold_o,
  output logic [1:0]           select_o,
  output logic [REG_WIDTH-1:0] caesar_key_o,
  output logic [REG_WIDTH-1:0] scytale_key_o,
  output logic [REG_WIDTH-1:0] zigzag_key_o,
  output logic                 done_o,
  output logic                 error_o
);

  state_t               state;
  sel_t                 pend_sel;
  logic [REG_WIDTH-1:0] pend_key;
  logic [REG_WIDTH-1:0] cur_key;
  logic                 req_valid;
  logic                 req_noop;
  logic                 mon_clear;
  logic                 drained;
  logic                 timed_out;

  // Counters only run while a change is actually draining.
  assign mon_clear = (state != DRAIN);

  drain_monitor #(
    .QUIET_CYCLES (QUIET_CYCLES),
    .DRAIN_TIMEOUT(DRAIN_TIMEOUT),
    .CNT_WIDTH    (CNT_WIDTH)
  ) u_drain_monitor (
    .clk_sys    (clk_sys),
    .rst        (rst),
    .valid_in   (valid_in_i),
    .valid_out  (valid_out_i),
    .engine_busy(engine_busy_i),
    .clear      (mon_clear),
    .drained    (drained),
    .timed_out  (timed_out)
  );

  // Key currently in force for the committed engine, for no-op detection.
  always_comb begin
    cur_key = '0;
    case (select_o)
      SEL_CAESAR:  cur_key = caesar_key_o;
      SEL_SCYTALE: cur_key = scytale_key_o;
      SEL_ZIGZAG:  cur_key = zigzag_key_o;
      default:     cur_key = '0;
    endcase
  end

  assign req_valid = sel_is_valid(req_select_i);
  assign req_noop  = req_valid && (req_select_i == select_o) && (req_key_i == cur_key);

  // Sequencer: all outputs registered; done_o follows COMMIT, error_o pulses.
  always_ff @(posedge clk_sys or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      pend_sel      <= SEL_CAESAR;
      pend_key      <= '0;
      select_o      <= SEL_CAESAR;
      caesar_key_o  <= '0;
      scytale_key_o <= '0;
      zigzag_key_o  <= '0;
      hold_o        <= 1'b0;
      done_o        <= 1'b0;
      error_o       <= 1'b0;
    end else begin
      done_o  <= 1'b0;
      error_o <= 1'b0;
      case (state)
        IDLE: begin
          hold_o <= 1'b0;
          if (req_i) begin
            if (!req_valid) begin
              error_o <= 1'b1;
            end else begin
              pend_sel <= req_select_i;
              pend_key <= req_key_i;
              hold_o   <= 1'b1;
              if (req_noop) begin
                // Nothing to flush: the rewrite cannot change the datapath.
                state  <= COMMIT;
                done_o <= 1'b1;
              end else begin
                state <= DRAIN;
              end
            end
          end
        end

        DRAIN: begin
          hold_o <= 1'b1;
          if (req_i) begin
            if (!req_valid) begin
              error_o <= 1'b1;
            end else begin
              // Latest request wins; the drain window keeps running.
              pend_sel <= req_select_i;
              pend_key <= req_key_i;
            end
          end
          if (drained) begin
            state  <= COMMIT;
            done_o <= 1'b1;
          end else if (timed_out) begin
            state   <= IDLE;
            hold_o  <= 1'b0;
            error_o <= 1'b1;
          end
        end

        COMMIT: begin
          // Select and the addressed key change together, exactly once.
          select_o <= pend_sel;
          case (pend_sel)
            SEL_CAESAR:  caesar_key_o  <= pend_key;
            SEL_SCYTALE: scytale_key_o <= pend_key;
            SEL_ZIGZAG:  zigzag_key_o  <= pend_key;
            default:     ;
          endcase
          state  <= IDLE;
          hold_o <= 1'b0;
          if (req_i) begin
            error_o <= 1'b1;
          end
        end

        default: begin
          state  <= IDLE;
          hold_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_decryption_switch_ctrl.sv
// Scoreboard bench for decryption_switch_ctrl: directed requests push the
// expected done/error pulse (kind and cycle) into a queue; a negedge monitor
// pops and compares whenever the DUT pulses done_o or error_o.
module tb_decryption_switch_ctrl;

  localparam int RW = 16;
  localparam int QC = 4;
  localparam int DT = 64;

  logic          clk_sys = 1'b0;
  logic          rst = 1'b1;
  logic          req_i = 1'b0;
  logic [1:0]    req_select_i = 2'd0;
  logic [RW-1:0] req_key_i = '0;
  logic          valid_in_i = 1'b0;
  logic          valid_out_i = 1'b0;
  logic          engine_busy_i = 1'b0;
  logic          hold_o;
  logic [1:0]    select_o;
  logic [RW-1:0] caesar_key_o;
  logic [RW-1:0] scytale_key_o;
  logic [RW-1:0] zigzag_key_o;
  logic          done_o;
  logic          error_o;

  decryption_switch_ctrl #(
    .REG_WIDTH    (RW),
    .QUIET_CYCLES (QC),
    .DRAIN_TIMEOUT(DT),
    .CNT_WIDTH    (8)
  ) dut (
    .clk_sys      (clk_sys),
    .rst          (rst),
    .req_i        (req_i),
    .req_select_i (req_select_i),
    .req_key_i    (req_key_i),
    .valid_in_i   (valid_in_i),
    .valid_out_i  (valid_out_i),
    .engine_busy_i(engine_busy_i),
    .hold_o       (hold_o),
    .select_o     (select_o),
    .caesar_key_o (caesar_key_o),
    .scytale_key_o(scytale_key_o),
    .zigzag_key_o (zigzag_key_o),
    .done_o       (done_o),
    .error_o      (error_o)
  );

  always #5 clk_sys = ~clk_sys;

  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;

  typedef struct {
    bit is_done;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic expect_pulse(input bit is_done, input int at_cyc);
    exp_t e;
    e.is_done = is_done;
    e.cyc     = at_cyc;
    sb.push_back(e);
  endtask

  // Drive a one-cycle request; returns the cycle count right after the sampling edge.
  task automatic issue(input logic [1:0] sel, input logic [RW-1:0] key, output int t);
    @(negedge clk_sys);
    req_i        = 1'b1;
    req_select_i = sel;
    req_key_i    = key;
    @(posedge clk_sys);
    #1;
    t     = cyc;
    req_i = 1'b0;
  endtask

  task automatic check_cfg(input string tag, input logic [1:0] sel,
                           input logic [RW-1:0] kc, input logic [RW-1:0] ks,
                           input logic [RW-1:0] kz);
    check({tag, "_select"}, 32'(select_o), 32'(sel));
    check({tag, "_caesar"}, 32'(caesar_key_o), 32'(kc));
    check({tag, "_scytale"}, 32'(scytale_key_o), 32'(ks));
    check({tag, "_zigzag"}, 32'(zigzag_key_o), 32'(kz));
  endtask

  task automatic pulse_seen(input bit is_done);
    exp_t e;
    if (sb.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL unexpected_pulse: got %s at cycle %0d, expected none",
               is_done ? "done_o" : "error_o", cyc);
    end else begin
      e = sb.pop_front();
      check(is_done ? "pulse_kind_done" : "pulse_kind_error", 32'(is_done), 32'(e.is_done));
      check("pulse_cycle", cyc, e.cyc);
    end
  endtask

  // Monitor: every done/error pulse must match the next scoreboard entry.
  always @(negedge clk_sys) begin
    if (!rst) begin
      if (done_o) pulse_seen(1'b1);
      if (error_o) pulse_seen(1'b0);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test, expected finish within time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int t1;
    int tmp;

    // Reset values
    repeat (3) @(negedge clk_sys);
    rst = 1'b0;
    @(negedge clk_sys);
    check("rst_hold", 32'(hold_o), 0);
    check("rst_done", 32'(done_o), 0);
    check("rst_error", 32'(error_o), 0);
    check_cfg("rst", 2'd0, 16'h0, 16'h0, 16'h0);

    // Quiet path: scytale 0x0305, hold for QC+1 cycles, done on the last
    issue(2'd1, 16'h0305, t);
    expect_pulse(1'b1, t + QC);
    for (int k = 0; k <= QC; k++) begin
      @(negedge clk_sys);
      check("quiet_hold_high", 32'(hold_o), 1);
      if (k < QC) check("quiet_select_stable", 32'(select_o), 0);
    end
    @(negedge clk_sys);
    check("quiet_hold_low", 32'(hold_o), 0);
    check_cfg("quiet", 2'd1, 16'h0, 16'h0305, 16'h0);

    // Invalid select in IDLE: error next cycle, no hold
    issue(2'd3, 16'h1234, t);
    expect_pulse(1'b0, t);
    @(negedge clk_sys);
    check("inv_hold0", 32'(hold_o), 0);
    @(negedge clk_sys);
    check("inv_hold1", 32'(hold_o), 0);
    check_cfg("inv", 2'd1, 16'h0, 16'h0305, 16'h0);

    // No-op request: straight to COMMIT, one cycle of hold
    issue(2'd1, 16'h0305, t);
    expect_pulse(1'b1, t);
    @(negedge clk_sys);
    check("noop_hold_high", 32'(hold_o), 1);
    @(negedge clk_sys);
    check("noop_hold_low", 32'(hold_o), 0);

    // Activity at DRAIN cycles 2 and 5 pushes commit out to DRAIN cycle 9
    issue(2'd0, 16'h0011, t);
    expect_pulse(1'b1, t + 9);
    for (int k = 0; k <= 9; k++) begin
      @(negedge clk_sys);
      valid_out_i = (k == 1) || (k == 4);
      check("act_hold_high", 32'(hold_o), 1);
    end
    valid_out_i = 1'b0;
    @(negedge clk_sys);
    check("act_hold_low", 32'(hold_o), 0);
    check_cfg("act", 2'd0, 16'h0011, 16'h0305, 16'h0);

    // Replacement during DRAIN plus an invalid request mid-drain
    issue(2'd1, 16'h00AA, t1);
    issue(2'd2, 16'h0007, tmp);
    issue(2'd3, 16'h0000, tmp);
    expect_pulse(1'b0, t1 + 2);
    expect_pulse(1'b1, t1 + QC);
    for (int k = 2; k <= QC; k++) begin
      @(negedge clk_sys);
      check("repl_select_stable", 32'(select_o), 0);
    end
    @(negedge clk_sys);
    check("repl_hold_low", 32'(hold_o), 0);
    check_cfg("repl", 2'd2, 16'h0011, 16'h0305, 16'h0007);

    // Request arriving while in COMMIT is dropped with an error
    issue(2'd0, 16'h0022, t);
    expect_pulse(1'b1, t + QC);
    repeat (QC) @(posedge clk_sys);
    issue(2'd1, 16'h0099, tmp);
    expect_pulse(1'b0, t + QC + 1);
    @(negedge clk_sys);
    @(negedge clk_sys);
    check("commit_req_hold", 32'(hold_o), 0);
    check_cfg("commit_req", 2'd0, 16'h0022, 16'h0305, 16'h0007);

    // Datapath never quiet
    engine_busy_i = 1'b1;
    issue(2'd2, 16'h0100, t);
`ifdef DECRYPTION_SWITCH_TIMEOUT_EN
    expect_pulse(1'b0, t + DT);
    for (int k = 0; k < DT; k++) begin
      @(negedge clk_sys);
      if (k == DT - 1) check("to_hold_before", 32'(hold_o), 1);
    end
    @(negedge clk_sys);
    @(negedge clk_sys);
    engine_busy_i = 1'b0;
    check("to_hold_after", 32'(hold_o), 0);
    check_cfg("to", 2'd0, 16'h0022, 16'h0305, 16'h0007);
`else
    repeat (80) @(negedge clk_sys);
    check("busy_hold_stays", 32'(hold_o), 1);
    check_cfg("busy_mid", 2'd0, 16'h0022, 16'h0305, 16'h0007);
    engine_busy_i = 1'b0;
    expect_pulse(1'b1, cyc + QC);
    repeat (QC + 1) @(negedge clk_sys);
    check("busy_hold_low", 32'(hold_o), 0);
    check_cfg("busy_end", 2'd2, 16'h0022, 16'h0305, 16'h0100);
`endif

    // Reset in the middle of DRAIN
    issue(2'd1, 16'h0F0F, t);
    @(negedge clk_sys);
    @(negedge clk_sys);
    rst = 1'b1;
    #1;
    check("mid_rst_hold", 32'(hold_o), 0);
    check("mid_rst_done", 32'(done_o), 0);
    check("mid_rst_error", 32'(error_o), 0);
    check_cfg("mid_rst", 2'd0, 16'h0, 16'h0, 16'h0);
    @(negedge clk_sys);
    rst = 1'b0;
    repeat (8) @(negedge clk_sys);
    check("post_rst_hold", 32'(hold_o), 0);
    check_cfg("post_rst", 2'd0, 16'h0, 16'h0, 16'h0);

    @(negedge clk_sys);
    check("scoreboard_drained", sb.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
